// File: rtl/sp_ff_array_arb.sv
// sp_ff_array_arb: round-robin arbiter sharing one single-port FF array among NUM_REQ requesters.
// Latency: grant in the same cycle as req_valid; read data returned one cycle after the grant.
// Backpressure: req_ready is a one-hot grant; a requester holds its request until it is granted.
// Optional zero-fill clear sequencer is built only when SP_ARB_CLEAR_EN is defined.
module sp_ff_array_arb #(
  parameter int NUM_REQ = 2,
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk0,
  input  logic                       rst0,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*S_INDEX-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]           resp_rdata,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       csb0,
  output logic                       web0,
  output logic [S_INDEX-1:0]         addr0,
  output logic [WIDTH-1:0]           din0,
  input  logic [WIDTH-1:0]           dout0
);

  localparam int          PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);

  logic [PW-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0] r_resp_sel;
  logic [S_INDEX-1:0] r_last_addr;

  logic               w_clearing;
  logic               w_clr_start;
  logic [S_INDEX-1:0] w_clr_addr;
  logic               w_arb_en;
  logic               w_grant_vld;
  logic [PW-1:0]      w_grant_idx;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [PW:0]        w_scan;
  logic [PW:0]        w_ptr_sum;
  logic [PW-1:0]      w_ptr_nxt;
  logic               w_sel_we;
  logic [S_INDEX-1:0] w_sel_addr;
  logic [WIDTH-1:0]   w_sel_wdata;

`ifdef SP_ARB_CLEAR_EN
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [S_INDEX-1:0] r_clr_cnt;

  // State register for the clear sequencer.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Enter CLEAR on a request from IDLE; leave after the last entry is written.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_clr_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == {S_INDEX{1'b1}}) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Clear address walks 0..2**S_INDEX-1 and wraps back to 0 on exit.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0)            r_clr_cnt <= '0;
    else if (w_clearing) r_clr_cnt <= r_clr_cnt + S_INDEX'(1);
  end

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_clr_addr = r_clr_cnt;
`else
  logic w_unused_clear_req;

  assign w_unused_clear_req = clear_req;
  assign w_clearing         = 1'b0;
  assign w_clr_start        = 1'b0;
  assign w_clr_addr         = '0;
`endif

  // A clear in progress or starting this cycle blocks all grants.
  assign w_arb_en = !w_clearing && !w_clr_start;

  // Round-robin scan: first valid requester at or after rr_ptr, modulo NUM_REQ.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_scan >= NREQ) w_scan = w_scan - NREQ;
      if (w_arb_en && !w_grant_vld && req_valid[w_scan[PW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_scan[PW-1:0];
      end
    end
  end

  assign w_grant_oh = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;

  // Select the granted requester's command fields.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*S_INDEX +: S_INDEX];
        w_sel_wdata = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves to the requester after the one just granted.
  always_comb begin
    w_ptr_sum = {1'b0, w_grant_idx} + (PW+1)'(1);
    if (w_ptr_sum >= NREQ) w_ptr_sum = '0;
    w_ptr_nxt = w_ptr_sum[PW-1:0];
  end

  // Array drive: clear write, granted access, or a dummy read that flushes the registered write enable.
  always_comb begin
    req_ready = '0;
    csb0      = 1'b1;
    web0      = 1'b1;
    addr0     = '0;
    din0      = '0;
    if (!rst0) begin
      csb0 = 1'b0;
      if (w_clearing) begin
        web0  = 1'b0;
        addr0 = w_clr_addr;
      end else if (w_grant_vld) begin
        req_ready = w_grant_oh;
        web0      = ~w_sel_we;
        addr0     = w_sel_addr;
        din0      = w_sel_wdata;
      end else begin
        addr0 = r_last_addr;
      end
    end
  end

  // Arbitration pointer, read-response steering and last driven address.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_rr_ptr    <= '0;
      r_resp_sel  <= '0;
      r_last_addr <= '0;
    end else begin
      if (w_grant_vld) r_rr_ptr <= w_ptr_nxt;
      r_resp_sel <= (w_grant_vld && !w_sel_we) ? w_grant_oh : '0;
      if (!csb0) r_last_addr <= addr0;
    end
  end

  // Read data is the array output steered by the registered one-hot select.
  assign resp_valid = r_resp_sel;
  assign resp_rdata = dout0;
  assign clear_busy = w_clearing;

endmodule

// File: tb/tb_sp_ff_array_arb.sv
// tb_sp_ff_array_arb: directed and randomized checks of sp_ff_array_arb against a request-level model.
// Latency: outputs sampled on the falling edge, inputs driven just after the rising edge.
// Backpressure: stimulus keeps an ungranted request stable until the model says it was granted.
module tb_sp_ff_array_arb;

  localparam int NUM_REQ = 2;
  localparam int S_INDEX = 4;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 1 << S_INDEX;
  localparam int AW      = NUM_REQ * S_INDEX;
  localparam int DW      = NUM_REQ * WIDTH;
`ifdef SP_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic               clk0 = 1'b0;
  logic               rst0 = 1'b0;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_we;
  logic [AW-1:0]      req_addr;
  logic [DW-1:0]      req_wdata;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] resp_valid;
  logic [WIDTH-1:0]   resp_rdata;
  logic               clear_req;
  logic               clear_busy;
  logic               csb0;
  logic               web0;
  logic [S_INDEX-1:0] addr0;
  logic [WIDTH-1:0]   din0;
  logic [WIDTH-1:0]   dout0;

  always #5 clk0 = ~clk0;

  sp_ff_array_arb #(.NUM_REQ(NUM_REQ), .S_INDEX(S_INDEX), .WIDTH(WIDTH)) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  // Single-port FF array: inputs registered when selected, write commits one edge later.
  logic [WIDTH-1:0]   mem [DEPTH];
  logic               a_web  = 1'b1;
  logic [S_INDEX-1:0] a_addr = '0;
  logic [WIDTH-1:0]   a_din  = '0;
  always @(posedge clk0) begin
    if (!a_web) mem[a_addr] <= a_din;
    if (!csb0) begin
      a_web  <= web0;
      a_addr <= addr0;
      a_din  <= din0;
    end
  end
  assign dout0 = mem[a_addr];

  // Request-level model state.
  int                 n_total = 0;
  int                 n_bad   = 0;
  int                 m_ptr;
  int                 m_clr_left;
  int                 m_clr_addr;
  logic [S_INDEX-1:0] m_last_addr;
  logic [NUM_REQ-1:0] m_pend;
  logic [NUM_REQ-1:0] m_granted;
  logic [WIDTH-1:0]   m_pend_data;
  bit                 m_pend_known;
  logic [WIDTH-1:0]   shadow [DEPTH];
  bit                 known  [DEPTH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr        = 0;
    m_clr_left   = 0;
    m_clr_addr   = 0;
    m_last_addr  = '0;
    m_pend       = '0;
    m_granted    = '0;
    m_pend_known = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  req_ready,  '0);
    chk({tag, "_resp_valid"}, resp_valid, '0);
    chk({tag, "_clear_busy"}, clear_busy, 1'b0);
    chk({tag, "_csb0"},       csb0,       1'b1);
    chk({tag, "_web0"},       web0,       1'b1);
    chk({tag, "_addr0"},      addr0,      '0);
    chk({tag, "_din0"},       din0,       '0);
  endtask

  task automatic set_req(input int r, input bit v, input bit we, input int a, input logic [WIDTH-1:0] d);
    req_valid = (req_valid & ~(NUM_REQ'(1) << r)) | (NUM_REQ'(v) << r);
    req_we    = (req_we    & ~(NUM_REQ'(1) << r)) | (NUM_REQ'(we) << r);
    req_addr  = (req_addr  & ~(AW'({S_INDEX{1'b1}}) << (r*S_INDEX))) | (AW'(S_INDEX'(a)) << (r*S_INDEX));
    req_wdata = (req_wdata & ~(DW'({WIDTH{1'b1}}) << (r*WIDTH))) | (DW'(d) << (r*WIDTH));
  endtask

  // One clock cycle: predict from the current requests, compare at the falling edge, advance the model.
  task automatic step();
    int                 g;
    bit                 clr_start;
    bit                 clearing;
    logic [NUM_REQ-1:0] e_ready;
    logic               e_web;
    logic [S_INDEX-1:0] e_addr;
    logic [WIDTH-1:0]   e_din;
    @(negedge clk0);
    g         = -1;
    clr_start = 1'b0;
    clearing  = (m_clr_left > 0);
    if (!clearing) begin
      if (CLR_EN && clear_req) clr_start = 1'b1;
      else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int r;
          r = (m_ptr + k) % NUM_REQ;
          if (g < 0 && 1'(req_valid >> r)) g = r;
        end
      end
    end
    e_ready = '0;
    e_web   = 1'b1;
    e_addr  = m_last_addr;
    e_din   = '0;
    if (clearing) begin
      e_web  = 1'b0;
      e_addr = S_INDEX'(m_clr_addr);
    end else if (g >= 0) begin
      e_ready = NUM_REQ'(1) << g;
      e_web   = ~1'(req_we >> g);
      e_addr  = S_INDEX'(req_addr >> (g*S_INDEX));
      e_din   = WIDTH'(req_wdata >> (g*WIDTH));
    end
    chk("req_ready",  req_ready,  e_ready);
    chk("csb0",       csb0,       1'b0);
    chk("web0",       web0,       e_web);
    chk("addr0",      addr0,      e_addr);
    chk("din0",       din0,       e_din);
    chk("resp_valid", resp_valid, m_pend);
    chk("clear_busy", clear_busy, clearing);
    if (m_pend != '0 && m_pend_known) chk("resp_rdata", resp_rdata, m_pend_data);
    m_last_addr = e_addr;
    m_granted   = e_ready;
    m_pend      = '0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NUM_REQ;
      if (1'(req_we >> g)) begin
        shadow[e_addr] = e_din;
        known[e_addr]  = 1'b1;
      end else begin
        m_pend       = e_ready;
        m_pend_data  = shadow[e_addr];
        m_pend_known = known[e_addr];
      end
    end
    if (clearing) begin
      m_clr_addr++;
      m_clr_left--;
    end
    if (clr_start) begin
      m_clr_left = DEPTH;
      m_clr_addr = 0;
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i] = '0;
        known[i]  = 1'b1;
      end
    end
    @(posedge clk0);
    #1;
  endtask

  initial begin
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    clear_req = 1'b0;
    model_reset();
    rst0 = 1'b1;
    #1;
    chk_reset_outputs("por");
    @(posedge clk0);
    #1;
    rst0 = 1'b0;

    // Both valid out of reset: requester 0 first.
    set_req(0, 1, 0, 0, '0);
    set_req(1, 1, 0, 0, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    step();

    // Write then immediate read of the same address by the other requester.
    set_req(0, 1, 1, 3, 32'hDEADBEEF);
    step();
    set_req(0, 0, 0, 0, '0);
    set_req(1, 1, 0, 3, '0);
    step();
    set_req(1, 0, 0, 0, '0);
    step();

    // Seed addrs 1 and 2, then both requesters hold reads for four cycles.
    set_req(0, 1, 1, 1, 32'h1111_0001);
    step();
    set_req(0, 0, 0, 0, '0);
    set_req(1, 1, 1, 2, 32'h2222_0002);
    step();
    set_req(0, 1, 0, 1, '0);
    set_req(1, 1, 0, 2, '0);
    repeat (4) step();
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    step();

    // Write, three idle cycles, read a different entry, then read back the written one.
    set_req(0, 1, 1, 5, 32'hA5A5_5A5A);
    step();
    set_req(0, 0, 0, 0, '0);
    repeat (3) step();
    set_req(0, 1, 0, 6, '0);
    step();
    set_req(0, 1, 0, 5, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    step();

    // Clear pulse while requester 0 waits with a read of addr 0, then read addrs 0 and 15.
    set_req(0, 1, 0, 0, '0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (DEPTH) step();
    step();
    set_req(0, 1, 0, 15, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    step();

    // Asynchronous reset in the middle of a read response.
    set_req(0, 1, 0, 5, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    #1;
    rst0 = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    #1;
    rst0 = 1'b0;
    set_req(0, 1, 0, 1, '0);
    set_req(1, 1, 0, 2, '0);
    step();
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    step();

    // Randomized traffic with occasional clear pulses.
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!(1'(req_valid >> r) && !1'(m_granted >> r))) begin
          set_req(r, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, DEPTH-1)), $urandom);
        end
      end
      clear_req = ($urandom_range(0, 59) == 0);
      step();
    end
    clear_req = 1'b0;
    set_req(0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, '0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sp_ff_array_arb.md
# sp_ff_array_arb

Round-robin arbiter and sequencer that shares one single-port flip-flop array (`sp_ff_array`) between `NUM_REQ` requesters in the out-of-order core. It grants at most one read or write per cycle, drives the array's chip-select, write-enable, address and data inputs, and returns read data one cycle after grant. An optional clear sequencer walks every entry and writes zeros.

## Interface
- `NUM_REQ`, 2: number of requesters, ≥ 2.
- `S_INDEX`, 4: array address width; the array has 2**S_INDEX entries.
- `WIDTH`, 32: data width.

- `clk0`  in  1  clock.
- `rst0`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ×S_INDEX  per-requester address.
- `req_wdata`  in  NUM_REQ×WIDTH  per-requester write data.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when valid && ready.
- `resp_valid`  out  NUM_REQ  one-hot read-data valid.
- `resp_rdata`  out  WIDTH  read data, shared by all requesters.
- `clear_req`  in  1  start clear; ignored unless `SP_ARB_CLEAR_EN` is defined.
- `clear_busy`  out  1  clear in progress.
- `csb0`  out  1  array chip select, active-low.
- `web0`  out  1  array write enable, active-low.
- `addr0`  out  S_INDEX  array address.
- `din0`  out  WIDTH  array write data.
- `dout0`  in  WIDTH  array read data.

## Operation
- The array registers `web0`/`addr0`/`din0` on a clock edge only when `csb0`=0. A registered write commits at the following edge. `dout0` is combinational from the registered address.
- Registered state:
  - round-robin pointer `rr_ptr` (log2 NUM_REQ bits);
  - FSM state in {IDLE, CLEAR};
  - clear counter (S_INDEX bits);
  - `resp_sel` (one-hot) recording the last read grant.
- IDLE arbitration (combinational):
  - Scan requesters starting at `rr_ptr`, wrapping modulo NUM_REQ. The first one with `req_valid`=1 is granted.
  - `req_ready[g]`=1 for the granted requester only.
  - Array drive for a grant: `csb0`=0, `web0`=~`req_we[g]`, `addr0`=`req_addr[g]`, `din0`=`req_wdata[g]`.
  - On any grant, `rr_ptr` ← (g+1) mod NUM_REQ.
- No grant in IDLE:
  - `csb0`=0, `web0`=1, `addr0`=last driven address, `din0`=0.
  - This dummy read deasserts the array's registered write enable, so a stale write is never repeated.
- Requesters must hold valid/we/addr/wdata stable while valid && !ready. `req_ready` may depend on `req_valid` of the same cycle.
- Read grant in cycle t:
  - `resp_sel` ← one-hot(g) at edge t+1.
  - In cycle t+1, `resp_valid` = `resp_sel` and `resp_rdata` = `dout0`, passed through combinationally.
  - `resp_sel` clears at edge t+2 unless another read was granted in t+1.
- A write grant produces no response.
- Read-after-write: a read granted in the cycle immediately after a write to the same address returns the new data. The array's write commit and read-address capture coincide at the same edge. No forwarding logic is required.
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=don't-care (`dout0`), `clear_busy`=0, `csb0`=1, `web0`=1, `addr0`=0, `din0`=0. `rr_ptr`=0, state=IDLE.
- Reset asserted mid-operation: all state returns to reset values immediately, and any in-flight read response is dropped.

## Timing
- Grant decision: same cycle as `req_valid`. Read latency is 1 cycle from grant to `resp_valid`.
- Throughput is one operation per cycle. Back-to-back reads from different requesters yield `resp_valid` on consecutive cycles, each one-hot to the correct requester.
- The round-robin pointer guarantees any continuously valid requester is granted within NUM_REQ cycles.

## Configuration
- `SP_ARB_CLEAR_EN` defined:
  - `clear_req`=1 in IDLE enters CLEAR at the next edge. `clear_req` takes priority over same-cycle requests; no grant is issued that cycle.
  - In CLEAR: `req_ready`=0 and `clear_busy`=1. The array is driven with `csb0`=0, `web0`=0, `addr0`=counter, `din0`=0.
  - The counter increments from 0 to 2**S_INDEX−1. After the last address, the FSM returns to IDLE. CLEAR lasts exactly 2**S_INDEX cycles.
  - `clear_req` during CLEAR is ignored.
  - A read granted in the cycle before CLEAR entry still returns valid data.
  - `rr_ptr` is unchanged by a clear.
- `SP_ARB_CLEAR_EN` undefined:
  - No FSM or counter is built.
  - `clear_req` is ignored and `clear_busy` is tied to 0.

## Test plan
- Reset with `rst0` pulsed asynchronously mid-cycle → outputs immediately at reset values; first grant after release goes to requester 0 when both are valid.
- Requester 0 writes 0xDEADBEEF to addr 3, then requester 1 reads addr 3 in the next cycle → `resp_valid`=2'b10 one cycle later with `resp_rdata`=0xDEADBEEF.
- Both requesters hold reads of addrs 1 and 2 valid for 4 cycles → grants alternate 01,10,01,10; responses alternate accordingly, one cycle behind.
- Write followed by 3 idle cycles, then a read of a different address → the written entry is unchanged and holds the written value; the idle cycles show `csb0`=0, `web0`=1.
- `SP_ARB_CLEAR_EN`, S_INDEX=4: `clear_req` pulsed while requester 0 is valid → no grant for 16 cycles with `clear_busy`=1; afterwards, reads of addrs 0 and 15 return 0 and requester 0 is granted on the first IDLE cycle.
- `SP_ARB_CLEAR_EN` undefined: `clear_req` pulsed → `clear_busy` stays 0 and grants continue uninterrupted.
